// File: rtl/aes_inv_ctrl.sv
// Step sequencer for the AES-128 inverse cipher: forward key expansion, then
// inverse rounds. It drives a state code and a round index to the datapath.
//
// state | meaning
// IDLE  | waiting for start; cs=STL, count=0
// RUN   | issuing steps k=0..51; a held cycle shows STL and does not advance k
module aes_inv_ctrl #(
  parameter int NR = 10,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          hold,
  output logic [2:0]    cs,
  output logic [CW-1:0] count,
  output logic          busy,
  output logic          done
);

  localparam logic [2:0] RES = 3'b000;
  localparam logic [2:0] STL = 3'b001;
  localparam logic [2:0] ADD = 3'b010;
  localparam logic [2:0] SUB = 3'b011;
  localparam logic [2:0] SHI = 3'b100;
  localparam logic [2:0] MIX = 3'b101;
  localparam logic [2:0] INV = 3'b110;
  localparam logic [2:0] FIN = 3'b111;

  localparam logic [5:0] K_ARK = 6'(NR + 1);
  localparam logic [5:0] K_RND = 6'(NR + 2);
  localparam logic [5:0] K_FR  = 6'(4 * NR + 8);
  localparam logic [5:0] K_FIN = 6'(4 * NR + 11);

  typedef enum logic [1:0] {
    IDLE = 2'b01,
    RUN  = 2'b10
  } state_t;

  state_t state;
  logic [5:0] k;

  logic [2:0]    step_cs;
  logic [CW-1:0] step_cnt;
  logic [5:0]    rnd_ofs;
  logic [1:0]    fin_ofs;

  // Inverse rounds: rnd_ofs[5:2] is rounds elapsed, rnd_ofs[1:0] the phase.
  always_comb begin
    step_cs  = STL;
    step_cnt = '0;
    rnd_ofs  = k - K_RND;
    fin_ofs  = 2'(k - K_FR);
    if (k == 6'd0) begin
      step_cs = RES;
    end else if (k < K_ARK) begin
      step_cs  = INV;
      step_cnt = CW'(k);
    end else if (k == K_ARK) begin
      step_cs  = ADD;
      step_cnt = CW'(NR);
    end else if (k < K_FR) begin
      step_cnt = CW'(6'(NR) - {2'b00, rnd_ofs[5:2]});
      case (rnd_ofs[1:0])
        2'd0:    step_cs = SHI;
        2'd1:    step_cs = SUB;
        2'd2:    step_cs = ADD;
        default: step_cs = MIX;
      endcase
    end else if (k < K_FIN) begin
      step_cnt = CW'(1);
      case (fin_ofs)
        2'd0:    step_cs = SHI;
        2'd1:    step_cs = SUB;
        default: step_cs = ADD;
      endcase
    end else begin
      step_cs = FIN;
    end
  end

  // k always names the next step to issue; k past FIN means FIN is on the bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k     <= '0;
      cs    <= STL;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= RUN;
            k     <= 6'd1;
            cs    <= RES;
            count <= '0;
            busy  <= 1'b1;
          end else begin
            k     <= '0;
            cs    <= STL;
            count <= '0;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          if (k > K_FIN) begin
            state <= IDLE;
            k     <= '0;
            cs    <= STL;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
          end else if (hold) begin
            cs   <= STL;
            done <= 1'b0;
          end else begin
            cs    <= step_cs;
            count <= step_cnt;
            done  <= (k == K_FIN);
            k     <= k + 6'd1;
          end
        end
        default: begin
          state <= IDLE;
          k     <= '0;
          cs    <= STL;
          count <= '0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_ctrl.sv
// Bench for aes_inv_ctrl: directed scenarios plus random start/hold/rst traffic,
// compared each cycle against a step-list reference model.
module tb_aes_inv_ctrl;

  localparam logic [2:0] RES = 3'b000;
  localparam logic [2:0] STL = 3'b001;
  localparam logic [2:0] ADD = 3'b010;
  localparam logic [2:0] SUB = 3'b011;
  localparam logic [2:0] SHI = 3'b100;
  localparam logic [2:0] MIX = 3'b101;
  localparam logic [2:0] INV = 3'b110;
  localparam logic [2:0] FIN = 3'b111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       hold = 1'b0;
  logic [2:0] cs;
  logic [7:0] count;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  // Reference: the decryption as an ordered list of (cs, count) steps.
  logic [2:0] seq_cs [52];
  logic [7:0] seq_cnt[52];
  int         seq_n;

  bit         m_run = 1'b0;
  int         m_ptr = 0;
  logic [2:0] m_cs  = STL;
  logic [7:0] m_cnt = 8'd0;
  logic       m_busy = 1'b0;
  logic       m_done = 1'b0;

  always #5 clk = ~clk;

  aes_inv_ctrl #(.NR(10), .CW(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .hold  (hold),
    .cs    (cs),
    .count (count),
    .busy  (busy),
    .done  (done)
  );

  function automatic void push(input logic [2:0] c, input int n);
    seq_cs[seq_n]  = c;
    seq_cnt[seq_n] = 8'(n);
    seq_n++;
  endfunction

  function automatic void build_seq();
    seq_n = 0;
    push(RES, 0);
    for (int i = 1; i <= 10; i++) push(INV, i);
    push(ADD, 10);
    for (int r = 9; r >= 1; r--) begin
      push(SHI, r + 1);
      push(SUB, r + 1);
      push(ADD, r + 1);
      push(MIX, r + 1);
    end
    push(SHI, 1);
    push(SUB, 1);
    push(ADD, 1);
    push(FIN, 0);
  endfunction

  function automatic void model_clock(input logic s, input logic h, input logic r);
    if (r) begin
      m_run = 0; m_cs = STL; m_cnt = 0; m_busy = 0; m_done = 0;
    end else if (!m_run) begin
      m_done = 0;
      if (s) begin
        m_run = 1; m_ptr = 1; m_cs = seq_cs[0]; m_cnt = seq_cnt[0]; m_busy = 1;
      end else begin
        m_cs = STL; m_cnt = 0; m_busy = 0;
      end
    end else if (m_ptr == seq_n) begin
      m_run = 0; m_cs = STL; m_cnt = 0; m_busy = 0; m_done = 0;
    end else if (h) begin
      m_cs = STL; m_done = 0;
    end else begin
      m_cs = seq_cs[m_ptr]; m_cnt = seq_cnt[m_ptr];
      m_done = (seq_cs[m_ptr] == FIN);
      m_ptr++;
    end
  endfunction

  task automatic tick(input logic s, input logic h, input logic r);
    start = s; hold = h; rst = r;
    @(posedge clk);
    model_clock(s, h, r);
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      tick(1'b1, 1'b0, 1'b1);
      checks++;
      if ({cs, count, busy, done} !== {STL, 8'd0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset c=%0d got cs=%0d cnt=%0d busy=%b done=%b want cs=1 cnt=0 busy=0 done=0",
                 c, cs, count, busy, done);
      end
    end
  endtask

  task automatic test_single();
    int busy_n = 0, done_n = 0, done_at = 0;
    tick(1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= 53; c++) begin
      checks++;
      if ({cs, count, busy, done} !== {m_cs, m_cnt, m_busy, m_done}) begin
        errors++;
        $display("FAIL single c=%0d got cs=%0d cnt=%0d busy=%b done=%b want cs=%0d cnt=%0d busy=%b done=%b",
                 c, cs, count, busy, done, m_cs, m_cnt, m_busy, m_done);
      end
      if (busy === 1'b1) busy_n++;
      if (done === 1'b1) begin done_n++; done_at = c; end
      tick(1'b0, 1'b0, 1'b0);
    end
    checks++;
    if (busy_n != 52 || done_n != 1 || done_at != 52) begin
      errors++;
      $display("FAIL single_timing got busy=%0d done_n=%0d done_at=%0d want 52 1 52", busy_n, done_n, done_at);
    end
  endtask

  task automatic test_hold();
    int busy_n = 0, stl_n = 0, inv5_n = 0, done_at = 0;
    tick(1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= 58; c++) begin
      checks++;
      if ({cs, count, busy, done} !== {m_cs, m_cnt, m_busy, m_done}) begin
        errors++;
        $display("FAIL hold c=%0d got cs=%0d cnt=%0d busy=%b done=%b want cs=%0d cnt=%0d busy=%b done=%b",
                 c, cs, count, busy, done, m_cs, m_cnt, m_busy, m_done);
      end
      if (busy === 1'b1) busy_n++;
      if (busy === 1'b1 && cs === STL) stl_n++;
      if (cs === INV && count === 8'd5) inv5_n++;
      if (done === 1'b1) done_at = c;
      tick(1'b0, (c >= 5 && c <= 7) || c == 54 || c == 55, 1'b0);
    end
    checks++;
    if (busy_n != 57 || stl_n != 5 || inv5_n != 1 || done_at != 57) begin
      errors++;
      $display("FAIL hold_timing got busy=%0d stl=%0d inv5=%0d done_at=%0d want 57 5 1 57",
               busy_n, stl_n, inv5_n, done_at);
    end
  endtask

  task automatic test_start_ignored();
    int done_at = 0, tail_bad = 0;
    tick(1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= 56; c++) begin
      checks++;
      if ({cs, count, busy, done} !== {m_cs, m_cnt, m_busy, m_done}) begin
        errors++;
        $display("FAIL start_ign c=%0d got cs=%0d cnt=%0d busy=%b done=%b want cs=%0d cnt=%0d busy=%b done=%b",
                 c, cs, count, busy, done, m_cs, m_cnt, m_busy, m_done);
      end
      if (done === 1'b1) done_at = c;
      if (c >= 53 && (cs !== STL || busy !== 1'b0)) tail_bad++;
      tick(c == 20 || c == 52, 1'b0, 1'b0);
    end
    checks++;
    if (done_at != 52 || tail_bad != 0) begin
      errors++;
      $display("FAIL start_ign_tail got done_at=%0d tail_bad=%0d want 52 0", done_at, tail_bad);
    end
  endtask

  task automatic test_reset_mid();
    int done_n = 0;
    tick(1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= 31; c++) begin
      checks++;
      if ({cs, count, busy, done} !== {m_cs, m_cnt, m_busy, m_done}) begin
        errors++;
        $display("FAIL rst_mid c=%0d got cs=%0d cnt=%0d busy=%b done=%b want cs=%0d cnt=%0d busy=%b done=%b",
                 c, cs, count, busy, done, m_cs, m_cnt, m_busy, m_done);
      end
      if (done === 1'b1) done_n++;
      if (c <= 30) tick(1'b0, 1'b0, c == 30);
    end
    checks++;
    if ({cs, count, busy} !== {STL, 8'd0, 1'b0} || done_n != 0) begin
      errors++;
      $display("FAIL rst_mid_abort got cs=%0d cnt=%0d busy=%b done_n=%0d want cs=1 cnt=0 busy=0 done_n=0",
               cs, count, busy, done_n);
    end
    tick(1'b1, 1'b0, 1'b0);
    checks++;
    if ({cs, count, busy} !== {RES, 8'd0, 1'b1}) begin
      errors++;
      $display("FAIL rst_mid_restart got cs=%0d cnt=%0d busy=%b want cs=0 cnt=0 busy=1", cs, count, busy);
    end
    for (int c = 2; c <= 53; c++) begin
      tick(1'b0, 1'b0, 1'b0);
      checks++;
      if ({cs, count, busy, done} !== {m_cs, m_cnt, m_busy, m_done}) begin
        errors++;
        $display("FAIL rst_mid_run c=%0d got cs=%0d cnt=%0d busy=%b done=%b want cs=%0d cnt=%0d busy=%b done=%b",
                 c, cs, count, busy, done, m_cs, m_cnt, m_busy, m_done);
      end
    end
  endtask

  task automatic test_back_to_back();
    int done_a = 0, done_b = 0, done_n = 0;
    tick(1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= 106; c++) begin
      checks++;
      if ({cs, count, busy, done} !== {m_cs, m_cnt, m_busy, m_done}) begin
        errors++;
        $display("FAIL b2b c=%0d got cs=%0d cnt=%0d busy=%b done=%b want cs=%0d cnt=%0d busy=%b done=%b",
                 c, cs, count, busy, done, m_cs, m_cnt, m_busy, m_done);
      end
      if (done === 1'b1) begin
        done_n++;
        if (done_n == 1) done_a = c; else done_b = c;
      end
      tick(c == 53, 1'b0, 1'b0);
    end
    checks++;
    if (done_n != 2 || done_a != 52 || done_b != 105) begin
      errors++;
      $display("FAIL b2b_timing got done_n=%0d at %0d,%0d want 2 at 52,105", done_n, done_a, done_b);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 900; c++) begin
      tick($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 149) == 0);
      checks++;
      if ({cs, count, busy, done} !== {m_cs, m_cnt, m_busy, m_done}) begin
        errors++;
        $display("FAIL random c=%0d got cs=%0d cnt=%0d busy=%b done=%b want cs=%0d cnt=%0d busy=%b done=%b",
                 c, cs, count, busy, done, m_cs, m_cnt, m_busy, m_done);
      end
    end
  endtask

  initial begin
    build_seq();
    test_reset();
    test_single();
    test_hold();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
